// File: rtl/div_count_rx.sv
// Receiver for the divided-counter stream: checks +1 (mod 16) steps every M clocks,
// locks after LOCK_N good steps, and reports step/err pulses and the measured period.
module div_count_rx #(
  parameter int M      = 10,
  parameter int LOCK_N = 3,
  parameter int PW     = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [3:0]    data,
  output logic          locked,
  output logic          step,
  output logic          err,
  output logic [3:0]    value,
  output logic [PW-1:0] period,
  output logic [7:0]    err_count
);

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [3:0]    data_q;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [3:0]    good_q, good_d;
  logic          locked_q, locked_d;
  logic          step_q, step_d;
  logic          err_q, err_d;
  logic [3:0]    value_q, value_d;
  logic [PW-1:0] period_q, period_d;
  logic [7:0]    err_count_q, err_count_d;

  logic          chg, good_chg, tmo;
  logic [3:0]    data_inc;
  logic [PW-1:0] ivl;

  always_comb begin
    chg      = (data != data_q);
    data_inc = data_q + 4'd1;
    // Saturated counter reports a saturated interval rather than wrapping to 0.
    ivl      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    good_chg = chg && (data == data_inc) && (ivl == PW'(M));
    tmo      = !chg && (cnt_q == PW'(M - 1));
    cnt_d    = chg ? '0 : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= HUNT;
      data_q      <= '0;
      cnt_q       <= '0;
      good_q      <= '0;
      locked_q    <= 1'b0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
      value_q     <= '0;
      period_q    <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data;
      cnt_q       <= cnt_d;
      good_q      <= good_d;
      locked_q    <= locked_d;
      step_q      <= step_d;
      err_q       <= err_d;
      value_q     <= value_d;
      period_q    <= period_d;
      err_count_q <= err_count_d;
    end
  end

  // A change on the timeout edge wins: tmo already excludes chg.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      HUNT: begin
        if (chg) begin
          state_d = TRACK;
          good_d  = '0;
        end
      end
      TRACK: begin
        if (good_chg) begin
          good_d = good_q + 4'd1;
          if (good_q + 4'd1 == 4'(LOCK_N)) state_d = LOCKED;
        end else if (chg) begin
          good_d = '0;
        end else if (tmo) begin
          state_d = HUNT;
        end
      end
      LOCKED: begin
        if (chg && !good_chg) begin
          state_d = TRACK;
          good_d  = '0;
        end else if (tmo) begin
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    locked_d    = (state_d == LOCKED);
    step_d      = (state_q == LOCKED) && good_chg;
    err_d       = (state_q == LOCKED) && ((chg && !good_chg) || tmo);
    value_d     = chg ? data : value_q;
    period_d    = (chg && state_q != HUNT) ? ivl : period_q;
    err_count_d = (err_d && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
  end

  assign locked    = locked_q;
  assign step      = step_q;
  assign err       = err_q;
  assign value     = value_q;
  assign period    = period_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_div_count_rx.sv
// Directed bench for div_count_rx: vector table of data changes plus hand sequences
// for timeout, err_count saturation and asynchronous reset.
module tb_div_count_rx;

  localparam int M  = 10;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic [3:0]    data;
  logic          locked, step, err;
  logic [3:0]    value;
  logic [PW-1:0] period;
  logic [7:0]    err_count;

  div_count_rx #(.M(M), .LOCK_N(3), .PW(PW)) dut (
    .clk(clk), .rstn(rstn), .data(data), .locked(locked), .step(step),
    .err(err), .value(value), .period(period), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  d;
    int          gap;
    logic        lk;
    logic        st;
    logic        er;
    logic [3:0]  val;
    logic [15:0] per;
    logic [7:0]  ec;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   seg_a_end, seg_b_end;
  logic [3:0] cur;
  int   exp_ec;

  function automatic vec_t mk(logic [3:0] d, int gap, logic lk, logic st, logic er,
                              logic [3:0] val, logic [15:0] per, logic [7:0] ec);
    vec_t v;
    v.d = d; v.gap = gap; v.lk = lk; v.st = st; v.er = er;
    v.val = val; v.per = per; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Caller sits just after a sampled edge; the new value is seen gap edges later.
  task automatic change(input logic [3:0] d, input int gap);
    repeat (gap - 1) @(negedge clk);
    data = d;
    @(negedge clk);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      change(vecs[i].d, vecs[i].gap);
      chk($sformatf("v%0d_locked", i), 32'(locked), 32'(vecs[i].lk));
      chk($sformatf("v%0d_step", i), 32'(step), 32'(vecs[i].st));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].er));
      chk($sformatf("v%0d_value", i), 32'(value), 32'(vecs[i].val));
      chk($sformatf("v%0d_period", i), 32'(period), 32'(vecs[i].per));
      chk($sformatf("v%0d_errcnt", i), 32'(err_count), 32'(vecs[i].ec));
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_locked"}, 32'(locked), 0);
    chk({nm, "_step"}, 32'(step), 0);
    chk({nm, "_err"}, 32'(err), 0);
    chk({nm, "_value"}, 32'(value), 0);
    chk({nm, "_period"}, 32'(period), 0);
    chk({nm, "_errcnt"}, 32'(err_count), 0);
  endtask

  initial begin
    // Lock-up from reset, then steady stepping and the 15->0 wrap.
    vecs.push_back(mk(4'd1, 4,  0, 0, 0, 4'd1, 16'd0,  8'd0));
    vecs.push_back(mk(4'd2, 10, 0, 0, 0, 4'd2, 16'd10, 8'd0));
    vecs.push_back(mk(4'd3, 10, 0, 0, 0, 4'd3, 16'd10, 8'd0));
    vecs.push_back(mk(4'd4, 10, 1, 0, 0, 4'd4, 16'd10, 8'd0));
    for (int d = 5; d < 16; d++)
      vecs.push_back(mk(4'(d), 10, 1, 1, 0, 4'(d), 16'd10, 8'd0));
    for (int d = 0; d < 4; d++)
      vecs.push_back(mk(4'(d), 10, 1, 1, 0, 4'(d), 16'd10, 8'd0));
    // Wrong value 3->5, relock after three good steps.
    vecs.push_back(mk(4'd5, 10, 0, 0, 1, 4'd5, 16'd10, 8'd1));
    vecs.push_back(mk(4'd6, 10, 0, 0, 0, 4'd6, 16'd10, 8'd1));
    vecs.push_back(mk(4'd7, 10, 0, 0, 0, 4'd7, 16'd10, 8'd1));
    vecs.push_back(mk(4'd8, 10, 1, 0, 0, 4'd8, 16'd10, 8'd1));
    vecs.push_back(mk(4'd9, 10, 1, 1, 0, 4'd9, 16'd10, 8'd1));
    // Early change after 9 clocks.
    vecs.push_back(mk(4'd10, 9,  0, 0, 1, 4'd10, 16'd9,  8'd2));
    vecs.push_back(mk(4'd11, 10, 0, 0, 0, 4'd11, 16'd10, 8'd2));
    vecs.push_back(mk(4'd12, 10, 0, 0, 0, 4'd12, 16'd10, 8'd2));
    vecs.push_back(mk(4'd13, 10, 1, 0, 0, 4'd13, 16'd10, 8'd2));
    vecs.push_back(mk(4'd14, 10, 1, 1, 0, 4'd14, 16'd10, 8'd2));
    seg_a_end = vecs.size();
    // After timeout: unchecked first change, TRACK timeout, TRACK bad value, relock.
    vecs.push_back(mk(4'd15, 3,  0, 0, 0, 4'd15, 16'd10, 8'd3));
    vecs.push_back(mk(4'd0,  10, 0, 0, 0, 4'd0,  16'd10, 8'd3));
    vecs.push_back(mk(4'd1,  12, 0, 0, 0, 4'd1,  16'd10, 8'd3));
    vecs.push_back(mk(4'd2,  10, 0, 0, 0, 4'd2,  16'd10, 8'd3));
    vecs.push_back(mk(4'd4,  10, 0, 0, 0, 4'd4,  16'd10, 8'd3));
    vecs.push_back(mk(4'd5,  10, 0, 0, 0, 4'd5,  16'd10, 8'd3));
    vecs.push_back(mk(4'd6,  10, 0, 0, 0, 4'd6,  16'd10, 8'd3));
    vecs.push_back(mk(4'd7,  10, 1, 0, 0, 4'd7,  16'd10, 8'd3));
    vecs.push_back(mk(4'd8,  10, 1, 1, 0, 4'd8,  16'd10, 8'd3));
    seg_b_end = vecs.size();

    rstn = 1'b0;
    data = 4'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;

    run_vecs(0, seg_a_end);

    // Freeze data while locked: timeout err exactly M clocks after the last change.
    repeat (M - 1) @(negedge clk);
    chk("tmo_pre_locked", 32'(locked), 1);
    chk("tmo_pre_err", 32'(err), 0);
    @(negedge clk);
    chk("tmo_err", 32'(err), 1);
    chk("tmo_locked", 32'(locked), 0);
    chk("tmo_errcnt", 32'(err_count), 3);
    @(negedge clk);
    chk("tmo_err_pulse", 32'(err), 0);

    run_vecs(seg_a_end, seg_b_end);

    // Drive err_count past 255 with repeated bad-value errors.
    cur    = 4'd8;
    exp_ec = 3;
    for (int i = 0; i < 254; i++) begin
      cur = cur + 4'd2;
      change(cur, M);
      exp_ec = (exp_ec == 255) ? 255 : exp_ec + 1;
      chk("sat_err", 32'(err), 1);
      chk("sat_step", 32'(step), 0);
      chk("sat_errcnt", 32'(err_count), 32'(exp_ec));
      for (int j = 0; j < 3; j++) begin
        cur = cur + 4'd1;
        change(cur, M);
      end
      chk("sat_relock", 32'(locked), 1);
    end
    chk("sat_final", 32'(err_count), 255);

    // Asynchronous reset mid-interval while locked.
    repeat (4) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk_all_zero("arst");
    data = 4'd0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    run_vecs(0, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/div_count_rx.md
Name: div_count_rx

Overview:
Receiving end of the divided-counter interface driven by div_count. It samples the 4-bit `data` bus in the `clk` domain and measures the interval between value changes. It checks that each change is a +1 (mod 16) step arriving exactly every M clocks. It locks onto a valid stream, then reports steps, errors and the measured period to downstream logic and to the bench.

Parameters:
M, 10, expected clocks between counter increments (same value as the div_count divisor); must be >= 2
LOCK_N, 3, consecutive good steps required to enter LOCKED; 1..15
PW, 16, width of period counter/output

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
data  input  4  counter value from div_count, synchronous to clk
locked  output  1  high while in LOCKED state
step  output  1  one-cycle pulse per accepted good increment while LOCKED
err  output  1  one-cycle pulse on protocol violation while LOCKED
value  output  4  last data value seen at a change
period  output  PW  clocks between the two most recent changes
err_count  output  8  number of err pulses, saturates at 255

Behaviour:
- Reset (rstn=0, async): state=HUNT, data_q=0, cnt=0, good=0; all outputs 0. Reset asserted mid-stream aborts immediately. After release, the first change is unchecked.
- data_q <= data every clock. Change event chg = (data != data_q), evaluated combinationally at each edge.
- Interval counter cnt:
  - cleared to 0 on the edge where chg is seen.
  - otherwise increments, saturating at 2^PW-1.
  - Interval measured at a change: ivl = cnt+1.
- Good change: chg && data == data_q+1 mod 16 && ivl == M. The wrap 15->0 is a legal +1.
- On every chg outside HUNT: period <= ivl, value <= data. In HUNT, only value updates.
- All outputs are registered: step/err/locked change one clk after the edge at which data_q differs from data.
- States and transitions:
  - HUNT:
    - on any chg -> TRACK, good=0.
    - The first interval is partial and is not checked.
  - TRACK:
    - good chg: good++. If good reaches LOCK_N -> LOCKED, locked<=1.
    - bad chg: good=0, stay in TRACK. No err pulse.
    - ivl would exceed M with no chg (cnt == M-1 and no chg): -> HUNT.
  - LOCKED:
    - good chg: step pulse.
    - bad chg (wrong value or wrong ivl): err pulse, err_count++, locked<=0, good=0 -> TRACK.
    - timeout (cnt == M-1 and no chg, i.e. an M+1 th clock would elapse): err pulse, err_count++, locked<=0 -> HUNT.
- step and err are never both high in the same cycle.
- err_count holds at 255 once reached.
- Only reset clears err_count.
- A change arriving exactly on the timeout edge counts as a chg, not a timeout: chg has priority.

Test Plan:
1. div_count #(10) drives data, rstn released at t=0. Required:
   - locked rises 1 clk after the 4th data change (1 unchecked + 3 good).
   - step pulses every 10 clks thereafter.
   - period=10, err_count=0.
2. Run across the wrap 15->0 while locked. Required: step pulse at the wrap, value=0, no err.
3. While locked, force data 3->5 at the correct time. Required:
   - err pulse, err_count=1, locked=0.
   - locked re-asserts after 3 further good steps.
4. While locked, change data after 9 clks instead of 10. Required: err pulse, period=9, locked=0, state TRACK.
5. While locked, freeze data. Required:
   - err pulse 10 clks after the last change (timeout), locked=0, HUNT.
   - On resuming, a relock takes 1 + LOCK_N changes.
6. Pull rstn low mid-interval while locked (asynchronous, between edges). Required:
   - all outputs 0 immediately.
   - err_count=0.
   - after release, behaves as scenario 1.
